pacman_motion_ctrl: RTL



---
 rtl/pacman_motion_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man movement register stage: buffers a direction request and, once per
// move_tick, steps the sprite along the cell grid. Turns happen only at cell centres.
module pacman_motion_ctrl #(
  parameter int X_ORG     = 150,
  parameter int Y_ORG     = 34,
  parameter int CELL      = 60,
  parameter int STEP      = 2,
  parameter int GRID_N    = 8,
  parameter int START_COL = 1,
  parameter int START_ROW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [3:0] btn_req,
  input  logic [3:0] legal_moves,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [2:0] cell_col,
  output logic [2:0] cell_row,
  output logic [3:0] current_direction,
  output logic       moving,
  output logic       at_center
);

  typedef enum logic {IDLE, MOVE} state_e;

  localparam logic [5:0] CellW = 6'(CELL);
  localparam logic [5:0] StepW = 6'(STEP);
  localparam logic [2:0] LastW = 3'(GRID_N - 1);

  state_e     state_q, state_d;
  logic [2:0] col_q, col_d, row_q, row_d;
  logic [5:0] xoff_q, xoff_d, yoff_q, yoff_d;
  logic [3:0] dir_q, dir_d, pend_q, pend_d;

  logic [3:0] step_dir;
  logic [3:0] in_grid;
  logic       centre;
  logic       req_onehot;
  logic       pend_legal, dir_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= 3'(START_COL);
      row_q   <= 3'(START_ROW);
      xoff_q  <= '0;
      yoff_q  <= '0;
      dir_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xoff_q  <= xoff_d;
      yoff_q  <= yoff_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end
  end

  // Exits that would leave the grid are masked out regardless of legal_moves.
  assign in_grid    = {col_q != '0, col_q != LastW, row_q != '0, row_q != LastW};
  assign centre     = (xoff_q == '0) && (yoff_q == '0);
  assign req_onehot = (btn_req != '0) && ((btn_req & (btn_req - 4'd1)) == '0);
  assign pend_legal = |(pend_q & legal_moves & in_grid);
  assign dir_legal  = |(dir_q & legal_moves & in_grid);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    step_dir = '0;
    col_d    = col_q;
    row_d    = row_q;
    xoff_d   = xoff_q;
    yoff_d   = yoff_q;

    if (move_tick) begin
      if (centre) begin
        if (pend_q != '0 && pend_legal) begin
          dir_d    = pend_q;
          pend_d   = '0;
          step_dir = pend_q;
          state_d  = MOVE;
        end else if (dir_q != '0 && dir_legal) begin
          step_dir = dir_q;
          state_d  = MOVE;
        end else begin
          state_d  = IDLE;
        end
      end else begin
        state_d = MOVE;
        if (pend_q == {dir_q[2], dir_q[3], dir_q[0], dir_q[1]}) begin
          dir_d    = pend_q;
          pend_d   = '0;
          step_dir = pend_q;
        end else begin
          step_dir = dir_q;
        end
      end
    end

    // A request on the tick cycle overrides the clear so it is used next tick.
    if (req_onehot) pend_d = btn_req;

    case (step_dir)
      4'b0100: begin
        if (xoff_q + StepW == CellW) begin
          col_d  = col_q + 3'd1;
          xoff_d = '0;
        end else xoff_d = xoff_q + StepW;
      end
      4'b1000: begin
        if (xoff_q == '0) begin
          col_d  = col_q - 3'd1;
          xoff_d = CellW - StepW;
        end else xoff_d = xoff_q - StepW;
      end
      4'b0001: begin
        if (yoff_q + StepW == CellW) begin
          row_d  = row_q + 3'd1;
          yoff_d = '0;
        end else yoff_d = yoff_q + StepW;
      end
      4'b0010: begin
        if (yoff_q == '0) begin
          row_d  = row_q - 3'd1;
          yoff_d = CellW - StepW;
        end else yoff_d = yoff_q - StepW;
      end
      default: ;
    endcase
  end

  always_comb begin
    xpos              = 10'(X_ORG) + 10'(col_q) * 10'(CELL) + 10'(xoff_q);
    ypos              = 10'(Y_ORG) + 10'(row_q) * 10'(CELL) + 10'(yoff_q);
    cell_col          = col_q;
    cell_row          = row_q;
    current_direction = dir_q;
    moving            = (state_q == MOVE);
    at_center         = centre;
  end

endmodule
